ram_frame_ctrl: RTL and testbench

Frame buffer controller that sits directly upstream of `singleport_ram` and owns all of its ports. It accepts one frame of words on a valid/ready input stream and writes them to sequential RAM addresses from 0. It then reads the frame back in order and emits it on a valid/ready output stream with full backpressure support. The RAM is single-port, so filling and draining alternate and never overlap.

---
 rtl/ram_frame_ctrl_pkg.sv | 14 +
 rtl/ram_rd_skid.sv | 48 ++++
 rtl/ram_frame_ctrl.sv | 127 ++++++++++++
 tb/tb_ram_frame_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_frame_ctrl_pkg.sv
// Shared types for the frame buffer controller: FSM state encoding and address-width sizing.
package ram_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DROP  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic int calc_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry register FIFO holding RAM read data (plus last flag) for the output stream.
// Zero added latency beyond the register stage; holds head stable while m_ready is low.
module ram_rd_skid #(
    parameter int data_width = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_valid,
    input  logic [data_width-1:0] wr_data,
    input  logic                  wr_last,
    output logic [data_width-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [1:0]            count
);

    logic [data_width:0] entry [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic                pop;

    assign pop     = m_valid & m_ready;
    assign m_valid = (count != 2'd0);
    assign m_data  = entry[rd_ptr][data_width-1:0];
    assign m_last  = entry[rd_ptr][data_width] & m_valid;

    // The caller's credit check guarantees no write ever lands on a full FIFO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entry[0] <= '0;
            entry[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (wr_valid) begin
                entry[wr_ptr] <= {wr_last, wr_data};
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, wr_valid} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/ram_frame_ctrl.sv
// Captures one frame into a single-port RAM, then replays it on a valid/ready stream.
// Write in the accept cycle; first output 2 cycles into drain; full backpressure via 2-entry skid.
module ram_frame_ctrl
    import ram_frame_ctrl_pkg::*;
#(
    parameter int  data_width = 16,
    parameter int  ram_depth  = 1024,
    localparam int addr_width = calc_addr_width(ram_depth)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [data_width-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [data_width-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [addr_width-1:0] ram_addr,
    output logic                  ram_we,
    output logic [data_width-1:0] ram_data_in,
    input  logic [data_width-1:0] ram_data_out,
    input  logic                  ram_rd_valid,
    output logic [addr_width:0]   frame_len,
    output logic                  overflow
);

    localparam logic [addr_width:0] cnt_one   = (addr_width+1)'(1);
    localparam logic [addr_width:0] cnt_depth = (addr_width+1)'(ram_depth);
    localparam logic [addr_width:0] last_addr = (addr_width+1)'(ram_depth - 1);

    state_t              state;
    logic [addr_width:0] wr_addr;
    logic [addr_width:0] rd_addr;
    logic                rd_pend;
    logic                rd_pend_last;
    logic [1:0]          occ;
    logic [2:0]          used;
    logic                pop;
    logic                issue;
    logic                rd_last;

    assign pop     = m_valid & m_ready;
    // A word leaving the skid this cycle frees its slot, which keeps the stream at full rate.
    assign used    = {1'b0, occ} + {2'b0, rd_pend} - {2'b0, pop};
    assign issue   = (state == ST_DRAIN) && (rd_addr < frame_len) && (used < 3'd2);
    assign rd_last = (rd_addr == frame_len - cnt_one);

    assign ram_we      = (state == ST_FILL) & s_valid;
    assign ram_data_in = s_data;
    always_comb begin
        ram_addr = '0;
        if (state == ST_FILL) begin
            ram_addr = wr_addr[addr_width-1:0];
        end else if (state == ST_DRAIN) begin
            ram_addr = rd_addr[addr_width-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_FILL;
            s_ready      <= 1'b1;
            wr_addr      <= '0;
            rd_addr      <= '0;
            frame_len    <= '0;
            overflow     <= 1'b0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
        end else begin
            rd_pend      <= issue;
            rd_pend_last <= rd_last;
            case (state)
                ST_FILL: begin
                    if (s_valid) begin
                        wr_addr <= wr_addr + cnt_one;
                        if (s_last) begin
                            frame_len <= wr_addr + cnt_one;
                            state     <= ST_DRAIN;
                            s_ready   <= 1'b0;
                        end else if (wr_addr == last_addr) begin
                            frame_len <= cnt_depth;
                            overflow  <= 1'b1;
                            state     <= ST_DROP;
                        end
                    end
                end
                ST_DROP: begin
                    if (s_valid && s_last) begin
                        state   <= ST_DRAIN;
                        s_ready <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (issue) begin
                        rd_addr <= rd_addr + cnt_one;
                    end
                    if (pop && m_last) begin
                        state    <= ST_FILL;
                        s_ready  <= 1'b1;
                        wr_addr  <= '0;
                        rd_addr  <= '0;
                        overflow <= 1'b0;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    ram_rd_skid #(
        .data_width(data_width)
    ) u_skid (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_valid(rd_pend & ram_rd_valid),
        .wr_data (ram_data_out),
        .wr_last (rd_pend_last),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready),
        .count   (occ)
    );

endmodule

// File: tb/tb_ram_frame_ctrl.sv
// Directed bench for ram_frame_ctrl with a behavioural single-port RAM and an output scoreboard.
module tb_ram_frame_ctrl;

    localparam int DW    = 16;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clock;
    logic          reset_n;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;
    logic          ram_rd_valid;
    logic [AW:0]   frame_len;
    logic          overflow;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    ram_frame_ctrl #(.data_width(DW), .ram_depth(DEPTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_data_in (ram_data_in),
        .ram_data_out(ram_data_out),
        .ram_rd_valid(ram_rd_valid),
        .frame_len   (frame_len),
        .overflow    (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port RAM: write when we=1, otherwise read with data valid the next cycle.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_data_in;
        else        ram_data_out  <= mem[ram_addr];
        ram_rd_valid <= !ram_we;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives an n-beat frame; the expected stored words go to the scoreboard.
    task automatic send_frame(input int n, input int pattern);
        int            stored;
        logic [DW-1:0] d;
        stored = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check("s_ready_in", s_ready, 1);
            case (pattern)
                0:       d = DW'(i * 15);
                1:       d = DW'(i) ^ 16'hA5A5;
                default: d = DW'($urandom);
            endcase
            s_valid = 1'b1;
            s_data  = d;
            s_last  = (i == n - 1);
            if (i < stored) sb.push_back('{d: d, l: (i == stored - 1)});
        end
        @(negedge clock);
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("frame_len", frame_len, stored);
        check("overflow_set", overflow, (n > DEPTH) ? 1 : 0);
        check("s_ready_drain", s_ready, 0);
        check("m_valid_early", m_valid, 0);
    endtask

    // Consumes the drained frame, comparing every handshake against the scoreboard.
    task automatic drain(input int n, input bit rand_ready, input bit exp_ovf);
        int            got = 0;
        int            cyc = 0;
        int            first = -1;
        bit            done = 0;
        bit            held = 0;
        logic [DW-1:0] held_d = '0;
        exp_t          e;
        while (!done && cyc < 5000) begin
            @(negedge clock);
            cyc++;
            if (held) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, held_d);
            end
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid && first < 0) first = cyc;
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check("extra_word", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("m_data", m_data, e.d);
                    check("m_last", m_last, e.l);
                end
                got++;
                if (m_last) begin
                    done = 1;
                    check("overflow_drain", overflow, exp_ovf);
                end
            end
            held   = m_valid && !m_ready;
            held_d = m_data;
        end
        check("drain_done", done, 1);
        check("word_count", got, n);
        if (!rand_ready) begin
            check("first_valid", first, 2);
            check("turnaround", cyc + 1, n + 2);
        end
        @(negedge clock);
        check("s_ready_back", s_ready, 1);
        check("m_valid_idle", m_valid, 0);
        check("overflow_clr", overflow, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_frame_len", frame_len, 0);
        check("rst_overflow", overflow, 0);
        reset_n = 1'b1;

        send_frame(8, 0);
        drain(8, 0, 0);

        send_frame(1024, 1);
        drain(1024, 0, 0);

        send_frame(1030, 1);
        drain(1024, 0, 1);

        send_frame(64, 2);
        drain(64, 1, 0);

        // Reset in the middle of draining a 16-word frame.
        send_frame(16, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            m_ready = 1'b1;
            if (m_valid) begin
                exp_t e;
                e = sb.pop_front();
                check("pre_rst_data", m_data, e.d);
            end
        end
        reset_n = 1'b0;
        #1;
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_s_ready", s_ready, 1);
        check("mid_rst_frame_len", frame_len, 0);
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        send_frame(4, 2);
        drain(4, 0, 0);

        send_frame(1, 2);
        drain(1, 0, 0);

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
